lsu_ctrl: RTL and testbench

Load/store sequencer for the MEM stage. Takes the effective address produced by the address generation unit plus access size, sign mode and store data, and checks alignment. Drives a single-port data memory through a req/ack handshake with byte enables and lane steering, and returns the extended load data. Stalls the pipeline while an access is outstanding and reports misalignment and bus-timeout exceptions.

---
 rtl/lsu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the MEM stage: alignment check, byte-lane steering,
// req/ack memory handshake with bus timeout, and load-data extension.
module lsu_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_eff_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_exc,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_LD_ALIGN = 2'b01;
    localparam logic [1:0] EXC_ST_ALIGN = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic             unsigned_q;
    logic [1:0]       off_q;

    logic             misaligned;
    logic [3:0]       be_in;
    logic [31:0]      wdata_in;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;

    // Alignment and lane steering work on the live request inputs so the
    // registered bus fields are already correct on the first REQ cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        misaligned = 1'b0;
        be_in      = 4'b0000;
        wdata_in   = i_wdata;
        unique case (i_size)
            2'b00: begin
                be_in    = 4'b0001 << i_eff_addr[1:0];
                wdata_in = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = i_eff_addr[0];
                be_in      = i_eff_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in   = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |i_eff_addr[1:0];
                be_in      = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel  = i_mem_rdata[{off_q, 3'b000} +: 8];
        half_sel  = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        load_data = i_mem_rdata;
        unique case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_data = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_done     = 1'b0;
        o_mem_req  = 1'b0;
        o_stall    = 1'b0;
        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                o_stall = i_valid & ~i_reset;
                if (i_valid) begin
                    state_next = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                o_mem_req = 1'b1;
                o_stall   = 1'b1;
                if (i_mem_ack || cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt         <= '0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            off_q       <= 2'b00;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= 4'b0000;
            o_mem_wdata <= '0;
            o_rdata     <= '0;
            o_exc       <= EXC_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (misaligned) begin
                            o_rdata <= '0;
                            o_exc   <= i_we ? EXC_ST_ALIGN : EXC_LD_ALIGN;
                        end else begin
                            cnt         <= '0;
                            size_q      <= i_size;
                            unsigned_q  <= i_unsigned;
                            off_q       <= i_eff_addr[1:0];
                            o_mem_we    <= i_we;
                            o_mem_addr  <= {i_eff_addr[31:2], 2'b00};
                            o_mem_be    <= be_in;
                            o_mem_wdata <= wdata_in;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the final allowed cycle still completes normally.
                    if (i_mem_ack) begin
                        o_rdata <= o_mem_we ? 32'h0 : load_data;
                        o_exc   <= EXC_NONE;
                    end else if (cnt == CNT_LAST) begin
                        o_rdata <= '0;
                        o_exc   <= EXC_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scoreboarded completions plus inline bus,
// latency, stall and reset checks.
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_eff_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic [1:0]  o_exc;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  exc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    lsu_ctrl #(.MEM_TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .i_eff_addr  (i_eff_addr),
        .i_wdata     (i_wdata),
        .o_ready     (o_ready),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_exc       (o_exc),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // One access: drive the request, answer REQ with an ack on req cycle
    // ack_cycle (-1 never), pop the scoreboard when o_done appears.
    task automatic access(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_cycle, input logic [31:0] mem_rdata,
                          input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                          input logic [31:0] exp_mwdata, input int exp_req,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_exc,
                          input int exp_lat);
        int   cyc;
        int   req_cyc;
        int   stall_cyc;
        int   done_cyc;
        bit   done_seen;
        exp_t e;
        exp_t got;
        i_valid    = 1'b1;
        i_we       = we;
        i_size     = size;
        i_unsigned = uns;
        i_eff_addr = addr;
        i_wdata    = wdata;
        sb.push_back('{rdata: exp_rdata, exc: exp_exc});
        cyc       = 0;
        req_cyc   = 0;
        stall_cyc = 0;
        done_cyc  = 0;
        done_seen = 1'b0;
        #1;
        if (o_stall) stall_cyc++;
        while (!done_seen && cyc < 50) begin
            @(posedge i_clk);
            #1;
            i_mem_ack = 1'b0;
            cyc++;
            if (o_mem_req) begin
                req_cyc++;
                checks++;
                if ({o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata} !== {we, exp_maddr, exp_be, exp_mwdata}) begin
                    errors++;
                    $display("FAIL %s bus cycle %0d: got we=%b addr=%h be=%b wdata=%h, expected we=%b addr=%h be=%b wdata=%h",
                             name, req_cyc, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
                             we, exp_maddr, exp_be, exp_mwdata);
                end
                if (req_cyc == ack_cycle) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mem_rdata;
                end
            end
            if (o_stall) stall_cyc++;
            if (o_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                got       = '{rdata: o_rdata, exc: o_exc};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s result: o_done with empty scoreboard, got rdata=%h exc=%b", name, got.rdata, got.exc);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL %s result: got rdata=%h exc=%b, expected rdata=%h exc=%b",
                                 name, got.rdata, got.exc, e.rdata, e.exc);
                    end
                end
            end
        end
        i_mem_ack = 1'b0;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s timeout: no o_done within %0d cycles, expected after %0d", name, cyc, exp_lat);
        end else if (done_cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, done_cyc, exp_lat);
        end
        checks++;
        if (req_cyc != exp_req) begin
            errors++;
            $display("FAIL %s req cycles: got %0d, expected %0d", name, req_cyc, exp_req);
        end
        checks++;
        if (stall_cyc != exp_lat) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d, expected %0d", name, stall_cyc, exp_lat);
        end
        // i_valid is still high through DONE; it must not relaunch the access.
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_ready, o_done, o_mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL %s after done: got ready=%b done=%b req=%b, expected 1 0 0", name, o_ready, o_done, o_mem_req);
        end
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_we        = 1'b0;
        i_size      = 2'b00;
        i_unsigned  = 1'b0;
        i_eff_addr  = '0;
        i_wdata     = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        #2;
        checks++;
        if ({o_ready, o_stall, o_done, o_rdata, o_exc, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset state: got ready=%b stall=%b done=%b rdata=%h exc=%b req=%b we=%b addr=%h be=%b wdata=%h, expected ready=1 and all else 0",
                     o_ready, o_stall, o_done, o_rdata, o_exc, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata);
        end
        #11;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_loads();
        access("word_load",  1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 1, 32'hDEAD_BEEF,
               32'h0000_0104, 4'b1111, 32'h0, 1, 32'hDEAD_BEEF, 2'b00, 2);
        access("byte_load_s", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1, 32'h80AA_55CC,
               32'h0000_0100, 4'b1000, 32'h0, 1, 32'hFFFF_FF80, 2'b00, 2);
        access("byte_load_u", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 1, 32'h80AA_55CC,
               32'h0000_0100, 4'b1000, 32'h0, 1, 32'h0000_0080, 2'b00, 2);
        access("half_load_s", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h80AA_55CC,
               32'h0000_0100, 4'b1100, 32'h0, 1, 32'hFFFF_80AA, 2'b00, 2);
        access("half_load_lo", 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 1, 32'h80AA_F00D,
               32'h0000_0100, 4'b0011, 32'h0, 1, 32'h0000_F00D, 2'b00, 2);
    endtask

    task automatic test_stores();
        access("half_store", 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 3, 32'hFFFF_FFFF,
               32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 3, 32'h0, 2'b00, 4);
        access("byte_store", 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_005A, 1, 32'hFFFF_FFFF,
               32'h0000_0200, 4'b0010, 32'h5A5A_5A5A, 1, 32'h0, 2'b00, 2);
    endtask

    task automatic test_misaligned();
        access("mis_word_load", 1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 0, 32'h0, 2'b01, 1);
        access("mis_half_store", 1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'h1234_5678, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 0, 32'h0, 2'b10, 1);
        access("size11_load", 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 0, 32'h0, 2'b01, 1);
    endtask

    task automatic test_timeout();
        access("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, -1, 32'h0,
               32'h0000_0300, 4'b1111, 32'h0, 4, 32'h0, 2'b11, 5);
        access("ack_last_cycle", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 4, 32'h1122_3344,
               32'h0000_0300, 4'b1111, 32'h0, 4, 32'h1122_3344, 2'b00, 5);
    endtask

    task automatic test_reset_mid_req();
        bit bad;
        i_valid    = 1'b1;
        i_we       = 1'b0;
        i_size     = 2'b10;
        i_unsigned = 1'b0;
        i_eff_addr = 32'h0000_0400;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req setup: got o_mem_req=%b, expected 1", o_mem_req);
        end
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if ({o_mem_req, o_stall, o_ready, o_done} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_mid_req outputs: got req=%b stall=%b ready=%b done=%b, expected 0 0 1 0",
                     o_mem_req, o_stall, o_ready, o_done);
        end
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset     = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hCAFE_F00D;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk);
            #1;
            i_mem_ack = 1'b0;
            if (o_done !== 1'b0 || o_mem_req !== 1'b0 || o_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stray_ack: got activity after reset (done=%b req=%b ready=%b), expected none",
                     o_done, o_mem_req, o_ready);
        end
        checks++;
        if ({o_rdata, o_exc} !== {32'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_req result regs: got rdata=%h exc=%b, expected 0 00", o_rdata, o_exc);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
